// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter fed by a small byte FIFO. The first start bit appears one clock after the byte is visible.
// Writes while full are dropped. Frames run back-to-back with no idle gap while the FIFO holds data.
module uart_transmitter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [15:0]                   shift_div_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_write_i,
    output logic                          tx_full_o,
    output logic                          tx_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count_o,
    output logic                          tx_active_o,
    output logic                          tx_complete_o,
    output logic                          tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          full, empty;
    logic          wr_en, pop;

    state_t        state, state_nxt;
    logic          tx, tx_nxt;
    logic          active, active_nxt;
    logic          complete, complete_nxt;
    logic [7:0]    sr, sr_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [15:0]   div_r, div_nxt;
    logic          bit_end;

    // Full/empty come from registered flags, so a write while full is dropped even if a pop coincides.
    assign wr_en   = tx_write_i && !full;
    assign bit_end = (cnt == div_r);

    always_comb begin
        count_nxt = count;
        case ({wr_en, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(FIFO_DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_nxt       = tx;
        active_nxt   = active;
        complete_nxt = 1'b0;
        sr_nxt       = sr;
        idx_nxt      = idx;
        cnt_nxt      = bit_end ? 16'd0 : cnt + 16'd1;
        div_nxt      = div_r;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt     = 1'b1;
                active_nxt = 1'b0;
                cnt_nxt    = 16'd0;
            end
            START: begin
                if (bit_end) begin
                    tx_nxt    = sr[0];
                    idx_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        sr_nxt  = {1'b0, sr[7:1]};
                        tx_nxt  = sr[1];
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    complete_nxt = 1'b1;
                    if (empty) begin
                        active_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Frame start, shared by the idle launch and the back-to-back launch at stop end.
        if (!empty && (state == IDLE || (state == STOP && bit_end))) begin
            pop        = 1'b1;
            sr_nxt     = mem[rd_ptr];
            div_nxt    = shift_div_i;
            tx_nxt     = 1'b0;
            active_nxt = 1'b1;
            cnt_nxt    = 16'd0;
            state_nxt  = START;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            tx       <= 1'b1;
            active   <= 1'b0;
            complete <= 1'b0;
            sr       <= '0;
            idx      <= '0;
            cnt      <= '0;
            div_r    <= '0;
        end else begin
            state    <= state_nxt;
            tx       <= tx_nxt;
            active   <= active_nxt;
            complete <= complete_nxt;
            sr       <= sr_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            div_r    <= div_nxt;
        end
    end

    assign tx_o          = tx;
    assign tx_active_o   = active;
    assign tx_complete_o = complete;
    assign tx_full_o     = full;
    assign tx_empty_o    = empty;
    assign tx_count_o    = count;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame timing, back-to-back, FIFO full/drop, simultaneous write+pop, reset.
module tb_uart_transmitter;
    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [15:0] shift_div_i;
    logic [7:0]  tx_data_i;
    logic        tx_write_i;
    logic        tx_full_o, tx_empty_o, tx_active_o, tx_complete_o, tx_o;
    logic [2:0]  tx_count_o;

    int tests = 0;
    int fails = 0;

    always #5 clock_i = ~clock_i;

    uart_transmitter #(.FIFO_DEPTH(4)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .shift_div_i   (shift_div_i),
        .tx_data_i     (tx_data_i),
        .tx_write_i    (tx_write_i),
        .tx_full_o     (tx_full_o),
        .tx_empty_o    (tx_empty_o),
        .tx_count_o    (tx_count_o),
        .tx_active_o   (tx_active_o),
        .tx_complete_o (tx_complete_o),
        .tx_o          (tx_o)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level at frame clock k (0 = first start-bit clock).
    function automatic logic fbit(input logic [7:0] b, input int d, input int k);
        int j;
        j = k / (d + 1);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    // Checks frame clocks k0..end, one sample per clock; optionally writes wr_b on the last clock.
    task automatic check_frame(input logic [7:0] b, input int d, input int k0, input logic cmp0,
                               input logic do_wr, input logic [7:0] wr_b);
        int len;
        len = 10 * (d + 1);
        for (int k = k0; k < len; k++) begin
            check("frame_tx", tx_o, fbit(b, d, k));
            check("frame_active", tx_active_o, 1'b1);
            if (k == k0) check("frame_complete_first", tx_complete_o, cmp0);
            else         check("frame_complete", tx_complete_o, 1'b0);
            if (do_wr && k == len - 1) begin
                tx_data_i  = wr_b;
                tx_write_i = 1'b1;
            end
            @(negedge clock_i);
            tx_write_i = 1'b0;
        end
    endtask

    task automatic end_idle();
        check("end_complete", tx_complete_o, 1'b1);
        check("end_tx", tx_o, 1'b1);
        check("end_active", tx_active_o, 1'b0);
        @(negedge clock_i);
        check("post_complete", tx_complete_o, 1'b0);
        check("post_tx", tx_o, 1'b1);
        check("post_active", tx_active_o, 1'b0);
    endtask

    task automatic start_single(input logic [7:0] b);
        tx_data_i  = b;
        tx_write_i = 1'b1;
        @(negedge clock_i);
        tx_write_i = 1'b0;
        check_cnt("wr_count", tx_count_o, 3'd1);
        check("wr_empty", tx_empty_o, 1'b0);
        check("wr_tx_still_high", tx_o, 1'b1);
        @(negedge clock_i);
        check("fall_tx", tx_o, 1'b0);
        check("fall_active", tx_active_o, 1'b1);
        check_cnt("fall_count", tx_count_o, 3'd0);
        check("fall_empty", tx_empty_o, 1'b1);
    endtask

    initial begin
        reset_i     = 1'b1;
        shift_div_i = 16'd3;
        tx_data_i   = 8'h00;
        tx_write_i  = 1'b0;
        #2;
        check("rst_tx", tx_o, 1'b1);
        check("rst_active", tx_active_o, 1'b0);
        check("rst_complete", tx_complete_o, 1'b0);
        check("rst_empty", tx_empty_o, 1'b1);
        check("rst_full", tx_full_o, 1'b0);
        check_cnt("rst_count", tx_count_o, 3'd0);
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);

        // Single byte, D=3; a divider change mid-frame must not affect this frame.
        start_single(8'h55);
        shift_div_i = 16'd9;
        check_frame(8'h55, 3, 0, 1'b0, 1'b0, 8'h00);
        end_idle();

        // Back-to-back, D=1: second write coincides with the idle pop.
        shift_div_i = 16'd1;
        tx_data_i   = 8'hA5;
        tx_write_i  = 1'b1;
        @(negedge clock_i);
        check_cnt("b2b_count_first", tx_count_o, 3'd1);
        tx_data_i = 8'h3C;
        @(negedge clock_i);
        tx_write_i = 1'b0;
        check_cnt("b2b_count_wr_pop", tx_count_o, 3'd1);
        check_frame(8'hA5, 1, 0, 1'b0, 1'b0, 8'h00);
        check_frame(8'h3C, 1, 0, 1'b1, 1'b0, 8'h00);
        end_idle();

        // Write on the stop-end pop clock with one entry queued, D=2.
        shift_div_i = 16'd2;
        start_single(8'h11);
        tx_data_i  = 8'h22;
        tx_write_i = 1'b1;
        @(negedge clock_i);
        tx_write_i = 1'b0;
        check_cnt("sim_count_before", tx_count_o, 3'd1);
        check_frame(8'h11, 2, 1, 1'b0, 1'b1, 8'h33);
        check_cnt("sim_count_after", tx_count_o, 3'd1);
        check_frame(8'h22, 2, 0, 1'b1, 1'b0, 8'h00);
        check_frame(8'h33, 2, 0, 1'b1, 1'b0, 8'h00);
        end_idle();
        check("sim_empty", tx_empty_o, 1'b1);

        // FIFO full, D=100: 0x06 is written while full and must be dropped.
        shift_div_i = 16'd100;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                check_cnt("full_count", tx_count_o, 3'd4);
                check("full_flag", tx_full_o, 1'b1);
            end
            tx_data_i  = 8'(i);
            tx_write_i = 1'b1;
            @(negedge clock_i);
        end
        tx_write_i = 1'b0;
        check_cnt("drop_count", tx_count_o, 3'd4);
        check("drop_full", tx_full_o, 1'b1);
        check("drop_empty", tx_empty_o, 1'b0);
        check_frame(8'h01, 100, 4, 1'b0, 1'b0, 8'h00);
        check_frame(8'h02, 100, 0, 1'b1, 1'b0, 8'h00);
        check_cnt("full_count_after_pop", tx_count_o, 3'd2);
        check_frame(8'h03, 100, 0, 1'b1, 1'b0, 8'h00);
        check_frame(8'h04, 100, 0, 1'b1, 1'b0, 8'h00);
        check_frame(8'h05, 100, 0, 1'b1, 1'b0, 8'h00);
        end_idle();
        check("full_drained", tx_empty_o, 1'b1);

        // D=0: one clock per bit.
        shift_div_i = 16'd0;
        start_single(8'hC3);
        check_frame(8'hC3, 0, 0, 1'b0, 1'b0, 8'h00);
        end_idle();

        // Reset during data bit 3 with a second byte queued.
        shift_div_i = 16'd3;
        start_single(8'h5A);
        tx_data_i  = 8'h66;
        tx_write_i = 1'b1;
        @(negedge clock_i);
        tx_write_i = 1'b0;
        check_cnt("rst_mid_count", tx_count_o, 3'd1);
        for (int k = 1; k < 17; k++) @(negedge clock_i);
        check("rst_mid_bit3", tx_o, 1'b1);
        check("rst_mid_active", tx_active_o, 1'b1);
        reset_i = 1'b1;
        #1;
        check("rst_async_tx", tx_o, 1'b1);
        check("rst_async_active", tx_active_o, 1'b0);
        check("rst_async_complete", tx_complete_o, 1'b0);
        check("rst_async_empty", tx_empty_o, 1'b1);
        check("rst_async_full", tx_full_o, 1'b0);
        check_cnt("rst_async_count", tx_count_o, 3'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        check("rst_flushed_tx", tx_o, 1'b1);
        check("rst_flushed_active", tx_active_o, 1'b0);
        check("rst_flushed_empty", tx_empty_o, 1'b1);
        start_single(8'h81);
        check_frame(8'h81, 3, 0, 1'b0, 1'b0, 8'h00);
        end_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART: it accepts bytes from the bus-side register logic into a small FIFO and shifts each one out as an 8N1 frame on `tx_o`. The frame format and per-bit timing match `uart_receiver` exactly, so both can share one `shift_div_i` register and loop back cleanly.

## Interface
- `FIFO_DEPTH`, default 4: number of byte entries in the transmit FIFO. Must be a power of two and at least 2.
- `clock_i`  in  1: the single clock domain.
- `reset_i`  in  1: reset, asynchronous and active-high.
- `shift_div_i`  in  16: bit period minus one, in clocks. One bit lasts `shift_div_i + 1` clocks.
- `tx_data_i`  in  8: byte to enqueue.
- `tx_write_i`  in  1: enqueue strobe, one byte per cycle.
- `tx_full_o`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `tx_empty_o`  out  1: FIFO holds 0 entries.
- `tx_count_o`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `tx_active_o`  out  1: a frame is on the line (start, data or stop bit).
- `tx_complete_o`  out  1: one-clock pulse when a stop bit finishes.
- `tx_o`  out  1: serial output, registered, idles high.

## Operation
- Reset values: `tx_o`=1, `tx_active_o`=0, `tx_complete_o`=0, `tx_empty_o`=1, `tx_full_o`=0, `tx_count_o`=0, FSM in IDLE.
- Reset applied mid-frame aborts the frame and flushes the FIFO. `tx_o` returns to 1 asynchronously.
- FIFO write: accepted when `tx_write_i` and `!tx_full_o`. A write while full is dropped silently, with no state change.
- Simultaneous write and pop:
  - Both take effect and `tx_count_o` is unchanged.
  - `full` and `empty` are evaluated on pre-edge occupancy, so a write when full is still dropped even if a pop occurs in the same cycle.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Occupancy is tracked with a separate counter ranging 0..`FIFO_DEPTH`.
- Bit timer: a 16-bit counter runs 0..`div_r`. A bit ends on the clock where counter == `div_r`, after which the counter resets to 0.
- `div_r` is a copy of `shift_div_i` latched at each frame start. Changing `shift_div_i` mid-frame has no effect until the next frame.
- FSM states:
  - IDLE: `tx_o`=1, `tx_active_o`=0. If the FIFO is non-empty: pop into the shift register, latch `div_r`, set `tx_o`<=0 and `tx_active_o`<=1, go to START.
  - START: hold 0 for one bit period, then `tx_o`<=sr[0], bit index=0, go to DATA.
  - DATA:
    - At each bit end the shift register shifts right and `tx_o`<=next bit, sending data LSB first.
    - After bit 7 ends, `tx_o`<=1 and the FSM goes to STOP.
  - STOP: hold 1 for one bit period. At its end:
    - `tx_complete_o`<=1.
    - If the FIFO is non-empty: pop, latch `div_r`, set `tx_o`<=0 and go to START. This is back-to-back transmission with no idle gap, and `tx_active_o` stays 1.
    - Otherwise: set `tx_active_o`<=0 and go to IDLE.
- `tx_complete_o` clears on the next clock unconditionally.

## Timing
- A write accepted at edge N makes the entry visible at edge N+1.
- In the IDLE case, the FSM pops at edge N+1 and `tx_o` falls after edge N+1.
- Frame length is exactly 10·(D+1) clocks from the `tx_o` falling edge to the stop-bit end, where D=`div_r`.
  - Start bit: clocks [0, D+1).
  - Data bit k: [(k+1)(D+1), (k+2)(D+1)).
  - Stop bit: [9(D+1), 10(D+1)).
- `tx_complete_o` is high for the single clock following the stop-bit end edge.
- When transmission is back-to-back, that clock is also the first clock of the next start bit.
- D=0 is legal and gives 1 clock per bit, a 10-clock frame.
- `tx_count_o`, `tx_full_o` and `tx_empty_o` are registered and update on the edge of the write or pop.

## Test plan
- Single byte: D=3, write 0x55 while idle → `tx_o` falls 1 clock later, then:
  - start bit 0 for 4 clocks;
  - data bits 1,0,1,0,1,0,1,0, 4 clocks each;
  - stop bit 1 for 4 clocks;
  - `tx_complete_o` high for 1 clock at clock 40, then `tx_active_o`=0.
- Back-to-back: D=1, write 0xA5 then 0x3C on consecutive cycles → two 20-clock frames with no high gap between the stop bit and the second start bit. Expect one `tx_complete_o` pulse per frame; `tx_active_o` stays 1 throughout.
- FIFO full: hold line busy, D=100.
  - Write 0x01..0x05 on 5 consecutive cycles. The first byte is popped at once, so the FIFO ends with 4 entries (0x02..0x05), `tx_full_o`=1, `tx_count_o`=4.
  - A 6th write of 0x06 is dropped.
  - The transmitted sequence is 0x01..0x05 and 0x06 never appears.
- Simultaneous write and pop: with FIFO at 1 entry, write in the same cycle as the stop-end pop → `tx_count_o` stays 1 and no byte is lost.
- Reset mid-frame: assert `reset_i` during data bit 3 → `tx_o`=1 immediately and all flags reset. After release, a write of 0x81 transmits a clean frame.
- Loopback: connect `tx_o` to `uart_receiver` with D=15 and send 256 random bytes → every `rx_data_o` matches and `rx_frame_err_o` is never set.
